// File: rtl/onehot_rr_arbiter.sv
// Round-robin packet arbiter. A registered one-hot grant selects one requester
// and drives the shared output stream through an AND-OR one-hot mux. The grant
// is held from the first beat of a packet through the beat carrying `last`;
// afterwards the priority pointer moves to the index just past the winner.
module onehot_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_valid,
    input  logic [N-1:0]       req_last,
    input  logic [N*WIDTH-1:0] req_data,
    output logic [N-1:0]       req_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic [N-1:0]       grant,
    output logic               busy
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]     ONE_N   = N'(1);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(N - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     grant_q, grant_d;

    logic [N-1:0]     hi_mask;
    logic [N-1:0]     req_hi;
    logic [N-1:0]     pick_hi;
    logic [N-1:0]     pick_all;
    logic [N-1:0]     pick;
    logic [PTR_W-1:0] g_idx;
    logic [PTR_W-1:0] ptr_inc;
    logic [WIDTH-1:0] mux_data;
    logic             xfer_last;

    // Priority pick: lowest requester at or above ptr, else lowest overall (wrap).
    always_comb begin
        hi_mask  = ~((ONE_N << ptr_q) - ONE_N);
        req_hi   = req_valid & hi_mask;
        pick_hi  = req_hi & (~req_hi + ONE_N);
        pick_all = req_valid & (~req_valid + ONE_N);
        pick     = (|req_hi) ? pick_hi : pick_all;
    end

    // Encode the held one-hot grant back to an index for the pointer update.
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                g_idx = g_idx | PTR_W'(i);
            end
        end
        ptr_inc = (g_idx == LAST_IX) ? '0 : (g_idx + ONE_P);
    end

    // One-hot AND-OR data mux; an all-zero grant yields all-zero data.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                mux_data = mux_data | req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign out_valid = |(req_valid & grant_q);
    assign out_last  = |(req_last & grant_q);
    assign out_data  = mux_data;
    assign req_ready = grant_q & {N{out_ready}};
    assign grant     = grant_q;
    assign busy      = (state_q == LOCKED);
    assign xfer_last = out_valid & out_ready & out_last;

    // Next-state logic: arbitrate in IDLE, hold the lock until the last beat moves.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = LOCKED;
                    grant_d = pick;
                end
            end
            LOCKED: begin
                if (xfer_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_inc;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, pointer and grant registers; reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench for onehot_rr_arbiter: reset, table-driven round robin,
// hand-written multi-cycle sequences, and a randomized run against a model.
module tb_onehot_rr_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 32;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic [N-1:0]       req_valid = '0;
    logic [N-1:0]       req_last  = '0;
    logic [N*WIDTH-1:0] req_data  = '0;
    logic               out_ready = 1'b0;
    logic [N-1:0]       req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [N-1:0]       grant;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    onehot_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_beat(input int i, input logic [WIDTH-1:0] v);
        req_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic rand_inputs();
        req_valid = N'($urandom);
        for (int i = 0; i < N; i++) begin
            req_last[i] = ($urandom_range(0, 2) == 0);
            set_beat(i, $urandom);
        end
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Reference model: owner index (-1 = none) and priority pointer as integers.
    int m_owner = -1;
    int m_ptr   = 0;

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
        end else if (m_owner < 0) begin
            m_owner <= rr_pick(req_valid, m_ptr);
        end else if (req_valid[m_owner] && out_ready && req_last[m_owner]) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % N;
        end
    end

    always @(negedge clk) begin : mdl_chk
        logic [N-1:0]     eg;
        logic [N-1:0]     er;
        logic             ev;
        logic             el;
        logic [WIDTH-1:0] ed;
        eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            er[m_owner] = out_ready;
            ev = req_valid[m_owner];
            el = req_last[m_owner];
            ed = req_data[m_owner*WIDTH +: WIDTH];
        end
        chk("mdl_grant", grant, eg);
        chk("mdl_busy", busy, m_owner >= 0);
        chk("mdl_out_valid", out_valid, ev);
        chk("mdl_out_last", out_last, el);
        chk("mdl_out_data", out_data, ed);
        chk("mdl_req_ready", req_ready, er);
        chk("onehot_grant", $countones(grant) <= 1, 1'b1);
    end

    typedef struct {
        logic [N-1:0]     valid;
        logic [N-1:0]     last;
        logic             rdy;
        logic [N-1:0]     eg;
        logic             ev;
        logic [WIDTH-1:0] ed;
    } rr_vec_t;

    typedef struct {
        logic v;
        logic r;
        int   beat;
        logic l;
    } bp_t;

    rr_vec_t          tbl[11];
    bp_t              bp[10];
    logic [WIDTH-1:0] got[$];

    initial begin
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 32'h0};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 32'haaaa_aaaa};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 32'h0};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 32'hbbbb_bbbb};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 32'h0};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 32'hcccc_cccc};
        tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 32'h0};
        tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 32'hdddd_dddd};
        tbl[8]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 32'h0};
        tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 32'haaaa_aaaa};
        tbl[10] = '{4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 32'h0};

        bp[0] = '{1'b1, 1'b1, 0, 1'b0};
        bp[1] = '{1'b1, 1'b0, 1, 1'b0};
        bp[2] = '{1'b1, 1'b0, 1, 1'b0};
        bp[3] = '{1'b1, 1'b0, 1, 1'b0};
        bp[4] = '{1'b1, 1'b0, 1, 1'b0};
        bp[5] = '{1'b0, 1'b1, 1, 1'b0};
        bp[6] = '{1'b0, 1'b1, 1, 1'b0};
        bp[7] = '{1'b1, 1'b1, 1, 1'b0};
        bp[8] = '{1'b1, 1'b1, 2, 1'b0};
        bp[9] = '{1'b1, 1'b1, 3, 1'b1};

        // Reset with random inputs: every output must be zero.
        rst_n = 1'b0;
        rand_inputs();
        repeat (2) begin
            @(posedge clk);
            #2;
            rand_inputs();
            @(negedge clk);
            chk("rst_grant", grant, '0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_last", out_last, 1'b0);
            chk("rst_out_data", out_data, '0);
            chk("rst_req_ready", req_ready, '0);
        end
        tick();
        rst_n     = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_grant", grant, '0);
            chk("idle_busy", busy, 1'b0);
            tick();
        end

        // Single-beat round robin from the table.
        set_beat(0, 32'haaaa_aaaa);
        set_beat(1, 32'hbbbb_bbbb);
        set_beat(2, 32'hcccc_cccc);
        set_beat(3, 32'hdddd_dddd);
        for (int i = 0; i < 11; i++) begin
            req_valid = tbl[i].valid;
            req_last  = tbl[i].last;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            chk("rr_grant", grant, tbl[i].eg);
            chk("rr_out_valid", out_valid, tbl[i].ev);
            chk("rr_out_data", out_data, tbl[i].ed);
            tick();
        end

        // Packet lock: requester 1 sends 3 beats while requester 2 waits.
        req_valid = 4'b0110;
        req_last  = 4'b0100;
        out_ready = 1'b1;
        set_beat(1, 32'h1111_0001);
        set_beat(2, 32'h2222_2222);
        @(negedge clk);
        chk("lock_idle_grant", grant, 4'b0000);
        tick();
        for (int b = 1; b <= 3; b++) begin
            set_beat(1, 32'h1111_0000 + b);
            req_last = (b == 3) ? 4'b0110 : 4'b0100;
            @(negedge clk);
            chk("lock_grant", grant, 4'b0010);
            chk("lock_req_ready", req_ready, 4'b0010);
            chk("lock_out_data", out_data, 32'h1111_0000 + b);
            chk("lock_out_last", out_last, b == 3);
            tick();
        end
        req_valid = 4'b0100;
        @(negedge clk);
        chk("lock_gap_grant", grant, 4'b0000);
        chk("lock_gap_ready2", req_ready[2], 1'b0);
        tick();
        @(negedge clk);
        chk("lock_next_grant", grant, 4'b0100);
        chk("lock_next_ready", req_ready, 4'b0100);
        chk("lock_next_data", out_data, 32'h2222_2222);
        tick();

        // Wrap priority: ptr is now 3, so requester 3 beats requester 0.
        req_valid = 4'b1001;
        req_last  = 4'b1111;
        set_beat(0, 32'h0a0a_0a0a);
        set_beat(3, 32'h0d0d_0d0d);
        @(negedge clk);
        chk("wrap_idle_grant", grant, 4'b0000);
        tick();
        @(negedge clk);
        chk("wrap_first_grant", grant, 4'b1000);
        chk("wrap_first_data", out_data, 32'h0d0d_0d0d);
        tick();
        @(negedge clk);
        chk("wrap_gap_grant", grant, 4'b0000);
        tick();
        @(negedge clk);
        chk("wrap_second_grant", grant, 4'b0001);
        chk("wrap_second_data", out_data, 32'h0a0a_0a0a);
        tick();
        req_valid = '0;

        // Backpressure and bubble on requester 1 (ptr is now 1).
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        out_ready = 1'b1;
        set_beat(1, 32'hbeef_0000);
        @(negedge clk);
        chk("bp_idle_grant", grant, 4'b0000);
        tick();
        for (int i = 0; i < 10; i++) begin
            req_valid = bp[i].v ? 4'b0010 : 4'b0000;
            req_last  = bp[i].l ? 4'b0010 : 4'b0000;
            out_ready = bp[i].r;
            set_beat(1, 32'hbeef_0000 + bp[i].beat);
            @(negedge clk);
            chk("bp_grant", grant, 4'b0010);
            chk("bp_out_valid", out_valid, bp[i].v);
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_end_grant", grant, 4'b0000);
        chk("bp_end_busy", busy, 1'b0);
        chk("bp_beat_count", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("bp_beat", (k < got.size()) ? 64'(got[k]) : 64'hdead, 64'(32'hbeef_0000 + k));
        end
        tick();

        // Reset during beat 2 of a 4-beat packet from requester 2 (ptr is now 2).
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        set_beat(2, 32'hc0de_0001);
        @(negedge clk);
        chk("rm_idle_grant", grant, 4'b0000);
        tick();
        @(negedge clk);
        chk("rm_beat1_data", out_data, 32'hc0de_0001);
        tick();
        set_beat(2, 32'hc0de_0002);
        @(negedge clk);
        chk("rm_beat2_grant", grant, 4'b0100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_async_grant", grant, 4'b0000);
        chk("rm_async_busy", busy, 1'b0);
        chk("rm_async_out_valid", out_valid, 1'b0);
        chk("rm_async_out_data", out_data, '0);
        chk("rm_async_req_ready", req_ready, '0);
        req_valid = 4'b0101;
        req_last  = 4'b0101;
        set_beat(0, 32'h0000_0f0f);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rm_release_grant", grant, 4'b0000);
        tick();
        @(negedge clk);
        chk("rm_restart_grant", grant, 4'b0001);
        tick();
        req_valid = '0;
        tick();

        // Randomized run with occasional resets; the model checker compares every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            rand_inputs();
            tick();
        end
        rst_n     = 1'b1;
        req_valid = '0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin packet arbiter that shares one output stream between N requesters by driving a registered one-hot grant into an internal `OneHotMux` (WIDTH, N) data path. A grant is held for a whole packet, from the first beat through the beat with `last`. The block sits in front of any shared single-consumer channel on the FPGA side, such as a memory-port or host-link queue. It provides fair, starvation-free access and strictly one-hot mux selects.

## Interface
Parameters:
- N, 4, number of requesters (N ≥ 2)
- WIDTH, 32, data beat width in bits

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N  per-requester beat valid
- req_last  in  N  per-requester last-beat-of-packet flag
- req_data  in  N*WIDTH  packed beats; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  N  per-requester beat accept
- out_valid  out  1  shared-channel beat valid
- out_data  out  WIDTH  shared-channel beat, the OneHotMux output selected by grant
- out_last  out  1  last flag of the granted requester
- out_ready  in  1  downstream accept
- grant  out  N  registered one-hot grant, or all-zero when no requester holds it
- busy  out  1  high while a packet grant is held

## Operation
- FSM has two states: IDLE and LOCKED. Internal pointer `ptr` (log2 N bits) holds the highest-priority index.
- IDLE:
  - If any `req_valid` is set, select the first asserted index scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Register that index into `grant` as one-hot and go to LOCKED.
  - If no `req_valid` is set, stay in IDLE with `grant` at 0.
- LOCKED, with granted index g:
  - `out_valid` = req_valid[g].
  - `out_data` = req_data[g].
  - `out_last` = req_last[g].
  - `req_ready[g]` = out_ready; all other `req_ready` bits are 0.
- Beat transfer: a beat transfers when out_valid && out_ready.
- Packet end: on a transfer with out_last = 1, the next edge sets grant to 0, sets ptr to (g+1) mod N, and returns the FSM to IDLE.
- Lock behaviour:
  - Deassertion of req_valid[g] mid-packet does not release the grant. out_valid drops and the lock is kept.
  - Requests from other indices are ignored until the packet ends.
- Wrap-around: ptr = N-1 advances to 0.
- A single-beat packet (valid and last on the first beat) completes in one LOCKED cycle.
- Outputs when grant = 0:
  - out_valid = 0, out_last = 0, out_data = 0, req_ready = 0.
- Invariant: `grant` is never multi-hot. Its popcount is always 0 or 1.
- busy = (state == LOCKED).

## Timing
- Reset, asserted asynchronously, immediately forces:
  - state = IDLE, ptr = 0, grant = 0, busy = 0
  - out_valid = 0, out_last = 0, out_data = 0, req_ready = 0
- Reset asserted mid-packet drops the packet without completing it. After release, arbitration restarts from ptr = 0.
- Request latency: req_valid first sampled high at edge t gives grant and out_valid at t+1, which is one cycle. An arbitration decision is a registered decision.
- Data path: req_data → out_data and out_ready → req_ready are combinational through the mux, with zero cycles of added latency.
- Turnaround: the edge that accepts the last beat clears grant. The next grant appears one cycle later, so there is exactly one idle cycle between back-to-back packets.
- Fairness: with all N requesters continuously requesting single-beat packets, grants rotate 0,1,…,N-1,0. Each requester is served within N packets of asserting req_valid.
- Backpressure: with out_ready = 0, state, grant, and ptr all hold.

## Test plan
- Reset values: drive rst_n = 0 with all inputs random → every output reads 0. After release with req_valid = 0 for 5 cycles → grant = 4'b0000 and busy = 0 throughout.
- Single-beat round-robin:
  - Stimulus: N = 4, all req_valid = 1, req_last = 1, out_ready = 1, req_data[i] = aaaa_aaaa / bbbb_bbbb / cccc_cccc / dddd_dddd.
  - Required: grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
  - Required: out_data is aaaa_aaaa, bbbb_bbbb, cccc_cccc, dddd_dddd on the granted cycles.
- Packet lock:
  - Stimulus: requester 1 sends 3 beats (last on the 3rd), with requester 2 requesting throughout.
  - Required: grant = 0010 for 3 transfer cycles, then 0000 for 1 cycle, then 0100.
  - Required: req_ready[2] = 0 until requester 2 is granted.
- Backpressure and bubble:
  - Stimulus: hold out_ready = 0 for 4 cycles mid-packet, and drop req_valid[g] for 2 cycles.
  - Required: grant is unchanged, out_valid follows req_valid[g], and no beat is lost or duplicated.
- Wrap priority: set ptr = 3 by completing a packet from requester 2, then assert req_valid = 4'b1001 → requester 3 is granted first, then requester 0.
- Reset mid-packet: assert rst_n = 0 during beat 2 of a 4-beat packet from requester 2 → grant = 0 with no clock edge needed. After release, with requesters 0 and 2 both requesting → requester 0 wins.
